core_mem: RTL
=============

CORE_MEM -- requirements
Module: core_MEM

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of bus-wait cycles before a bus error is declared.
REQ-002 SHALL have ports: clock in 1, the single clock; reset in 1, asynchronous active-high.
REQ-003 SHALL have pipeline inputs from EX: addr in 64 (ALU result or effective address); store_data in 64; W_regnum in 5; write_enable in 1; pc4 in 64; linkpc in 1.
REQ-004 SHALL have control inputs: mem_load_type in 2; mem_store_type in 2 (both 0=none, 1=byte, 2=word32, 3=dword); signed_byte in 1; signed_word in 1; flush in 1.
REQ-005 SHALL have data-bus ports: mem_req out 1; mem_we out 1; mem_addr out 64 (addr[63:3],3'b0); mem_wdata out 64; mem_be out 8; mem_ack in 1; mem_rdata in 64.
REQ-006 SHALL have outputs: stall out 1 (to hazard unit); MEM_data out 64 (registered writeback data, forwarding source); MEM_regnum out 5; MEM_write_enable out 1; addr_error out 1; bus_error out 1.

Function
REQ-007 SHALL implement FSM states IDLE and BUSY, plus a wait counter of width clog2(TIMEOUT+1).
REQ-008 Memory op = (mem_load_type!=0)|(mem_store_type!=0); if both are nonzero, the load SHALL win and the store is ignored.
REQ-009 Misaligned = word32 with addr[1:0]!=0, or dword with addr[2:0]!=0; a misaligned op SHALL issue no request, pulse addr_error for 1 cycle, and register MEM_write_enable=0.
REQ-010 IDLE with an aligned memory op and !flush SHALL assert stall combinationally, latch addr, byte enables, write data and control, and go to BUSY.
REQ-011 BUSY SHALL assert mem_req, with mem_addr/mem_we/mem_wdata/mem_be held stable from the latched values until mem_ack.
REQ-012 BUSY with !mem_ack SHALL assert stall, increment the counter, and register MEM_write_enable=0 (bubble).
REQ-013 BUSY with mem_ack SHALL deassert stall the same cycle, register the result on that edge, clear the counter, and go to IDLE; there SHALL be 1 request per instruction.
REQ-014 Store lanes: byte SHALL replicate store_data[7:0] x8 with be=1<<addr[2:0]; word32 SHALL replicate [31:0] x2 with be=8'h0F<<(4*addr[2]); dword SHALL use be=8'hFF.
REQ-015 Load extract: byte SHALL take rdata[8*addr[2:0]+:8], sign-extended iff signed_byte; word32 SHALL take rdata[32*addr[2]+:32], sign-extended iff signed_word; dword SHALL take rdata unchanged.
REQ-016 Load writeback SHALL register MEM_data=extracted value, MEM_regnum=W_regnum, MEM_write_enable=write_enable.
REQ-017 A store SHALL register MEM_write_enable=0.
REQ-018 Non-memory ops SHALL take 1 cycle with no stall, registering MEM_data=linkpc?pc4:addr and passing MEM_regnum/MEM_write_enable through.
REQ-019 Counter reaching TIMEOUT in BUSY without ack SHALL pulse bus_error for 1 cycle, drop mem_req, register MEM_write_enable=0, and go to IDLE.
REQ-020 Flush in IDLE SHALL discard the input and register MEM_write_enable=0 with no request.
REQ-021 Flush in BUSY SHALL NOT abort the bus transaction; its writeback is suppressed (MEM_write_enable=0 at ack).
REQ-022 mem_ack in IDLE SHALL be ignored.
REQ-023 stall SHALL never be asserted in the cycle following an ack or a timeout unless a new aligned memory op is present.

Reset
REQ-024 Reset asserted SHALL immediately force IDLE, counter=0, mem_req=0, mem_we=0, mem_be=0, stall=0, MEM_data=0, MEM_regnum=0, MEM_write_enable=0, addr_error=0, bus_error=0.
REQ-025 Reset mid-BUSY SHALL abandon the transaction; a late mem_ack after reset is ignored per REQ-022.

Verification
REQ-026 Byte load: addr=0x1005, signed_byte=1, rdata=0x0000_8000_0000_0000, ack after 2 cycles -> stall 3 cycles; MEM_data=0xFFFF_FFFF_FFFF_FF80; MEM_write_enable=1.
REQ-027 Word store: addr=0x2004, store_data=0xDEADBEEF -> mem_addr=0x2000; be=8'hF0; wdata=0xDEADBEEF_DEADBEEF; mem_we=1; MEM_write_enable=0 after ack.
REQ-028 Misaligned dword load at addr=0x3002 -> no mem_req; addr_error pulses once; stall=0.
REQ-029 Timeout: aligned load, ack never, TIMEOUT=4 -> bus_error pulses after 4 wait cycles; mem_req drops; FSM returns to IDLE.
REQ-030 Link: linkpc=1, pc4=0x400010, addr=0x55 -> next cycle MEM_data=0x400010, no stall.
REQ-031 Reset asserted in BUSY -> mem_req=0 within the same cycle; a later mem_ack produces no writeback.

Source files
------------

// File: rtl/core_mem.sv
// Memory stage: one bus request per load/store, stalling the pipeline until ack or timeout.
// Misaligned accesses raise addr_error and never reach the bus.
module core_mem #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] addr,
  input  logic [63:0] store_data,
  input  logic [4:0]  W_regnum,
  input  logic        write_enable,
  input  logic [63:0] pc4,
  input  logic        linkpc,
  input  logic [1:0]  mem_load_type,
  input  logic [1:0]  mem_store_type,
  input  logic        signed_byte,
  input  logic        signed_word,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_be,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        stall,
  output logic [63:0] MEM_data,
  output logic [4:0]  MEM_regnum,
  output logic        MEM_write_enable,
  output logic        addr_error,
  output logic        bus_error
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_reg;
  logic [CW-1:0] count_reg;
  logic [63:0]   lat_addr_reg;
  logic [63:0]   lat_wdata_reg;
  logic [7:0]    lat_be_reg;
  logic          lat_we_reg;
  logic [1:0]    lat_size_reg;
  logic          lat_signed_reg;
  logic [4:0]    lat_regnum_reg;
  logic          lat_wb_reg;
  logic          kill_reg;

  logic          is_load;
  logic          is_mem;
  logic          misaligned;
  logic          start;
  logic          busy;
  logic          timeout_hit;
  logic [1:0]    op_size;
  logic [7:0]    be_next;
  logic [63:0]   wdata_next;
  logic [7:0]    rd_byte;
  logic [31:0]   rd_word;
  logic [63:0]   load_val;

  // A load and a store in the same slot: the load wins.
  always_comb begin
    is_load    = mem_load_type != 2'd0;
    is_mem     = is_load || (mem_store_type != 2'd0);
    op_size    = is_load ? mem_load_type : mem_store_type;
    misaligned = (op_size == 2'd2 && addr[1:0] != 2'b00) ||
                 (op_size == 2'd3 && addr[2:0] != 3'b000);
    be_next    = 8'hFF;
    wdata_next = store_data;
    case (op_size)
      2'd1: begin
        be_next    = 8'h01 << addr[2:0];
        wdata_next = {8{store_data[7:0]}};
      end
      2'd2: begin
        be_next    = addr[2] ? 8'hF0 : 8'h0F;
        wdata_next = {2{store_data[31:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_byte = mem_rdata[{lat_addr_reg[2:0], 3'b000} +: 8];
    rd_word = mem_rdata[{lat_addr_reg[2], 5'b00000} +: 32];
    case (lat_size_reg)
      2'd1:    load_val = {{56{lat_signed_reg & rd_byte[7]}}, rd_byte};
      2'd2:    load_val = {{32{lat_signed_reg & rd_word[31]}}, rd_word};
      default: load_val = mem_rdata;
    endcase
  end

  assign busy        = (state_reg == BUSY);
  assign start       = (state_reg == IDLE) & is_mem & ~misaligned & ~flush & ~reset;
  assign timeout_hit = busy & ~mem_ack & (count_reg == LAST_WAIT);
  // The timeout cycle retires the instruction (as a bus error), so it releases the stall.
  assign stall       = start | (busy & ~mem_ack & ~timeout_hit);
  assign mem_req     = busy;
  assign mem_we      = busy & lat_we_reg;
  assign mem_be      = busy ? lat_be_reg : 8'h00;
  assign mem_addr    = {lat_addr_reg[63:3], 3'b000};
  assign mem_wdata   = lat_wdata_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      count_reg        <= '0;
      lat_addr_reg     <= '0;
      lat_wdata_reg    <= '0;
      lat_be_reg       <= '0;
      lat_we_reg       <= 1'b0;
      lat_size_reg     <= '0;
      lat_signed_reg   <= 1'b0;
      lat_regnum_reg   <= '0;
      lat_wb_reg       <= 1'b0;
      kill_reg         <= 1'b0;
      MEM_data         <= '0;
      MEM_regnum       <= '0;
      MEM_write_enable <= 1'b0;
      addr_error       <= 1'b0;
      bus_error        <= 1'b0;
    end else begin
      addr_error <= 1'b0;
      bus_error  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (flush) begin
            MEM_write_enable <= 1'b0;
          end else if (is_mem && misaligned) begin
            addr_error       <= 1'b1;
            MEM_write_enable <= 1'b0;
          end else if (is_mem) begin
            lat_addr_reg     <= addr;
            lat_wdata_reg    <= wdata_next;
            lat_be_reg       <= be_next;
            lat_we_reg       <= ~is_load;
            lat_size_reg     <= op_size;
            lat_signed_reg   <= (op_size == 2'd1) ? signed_byte : signed_word;
            lat_regnum_reg   <= W_regnum;
            lat_wb_reg       <= is_load & write_enable;
            kill_reg         <= 1'b0;
            count_reg        <= '0;
            MEM_write_enable <= 1'b0;
            state_reg        <= BUSY;
          end else begin
            MEM_data         <= linkpc ? pc4 : addr;
            MEM_regnum       <= W_regnum;
            MEM_write_enable <= write_enable;
          end
        end
        BUSY: begin
          MEM_write_enable <= 1'b0;
          // A flush seen at any point while waiting suppresses the eventual writeback.
          if (flush) kill_reg <= 1'b1;
          if (mem_ack) begin
            state_reg <= IDLE;
            count_reg <= '0;
            if (!lat_we_reg) begin
              MEM_data         <= load_val;
              MEM_regnum       <= lat_regnum_reg;
              MEM_write_enable <= lat_wb_reg & ~kill_reg & ~flush;
            end
          end else if (timeout_hit) begin
            state_reg <= IDLE;
            count_reg <= '0;
            bus_error <= 1'b1;
          end else begin
            count_reg <= count_reg + CW'(1);
          end
        end
      endcase
    end
  end

endmodule
